// File: rtl/inst_rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_loader_pkg
//  Description : Shared constants and FSM encoding for the instruction-store
//                loader and its fetch read port.
//  Revision    : 1.0  initial release
// ============================================================================
package inst_rom_loader_pkg;

    // Default store depth (log2 of word count)
    localparam int          INST_MEM_NUM_LOG2 = 10;

    // Loader byte bus width
    localparam int          LD_BYTE_W         = 8;

    // Core-side encodings
    localparam logic        RST_ENABLE        = 1'b1;
    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        CHIP_DISABLE      = 1'b0;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

    // Loader FSM: leaves LOAD only once, re-entered only through reset
    typedef enum logic [0:0] {
        LD_LOAD = 1'b0,
        LD_RUN  = 1'b1
    } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_rom_loader_word_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ld_word_pack
//  Description : Packs a big-endian byte stream into 32-bit words. The first
//                byte of a word lands in [31:24]. A word is emitted on its
//                4th byte, or early on the last byte with low lanes zeroed.
//  Revision    : 1.0  initial release
// ============================================================================
module ld_word_pack
    import inst_rom_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LD_BYTE_W-1:0] ld_byte,
    input  logic                 xfer,
    input  logic                 last,
    output logic [31:0]          word,
    output logic                 word_we
);

    // Lane index of the incoming byte (0 = most significant)
    logic [1:0]  r_lane;
    // Bytes already received for this word, newest in the low byte
    logic [23:0] r_shift;
    logic [4:0]  w_pad_sh;

    // Left-justify collected bytes plus the current one; unfilled lanes stay zero
    assign w_pad_sh = {~r_lane, 3'b000};
    assign word     = {r_shift, ld_byte} << w_pad_sh;
    assign word_we  = xfer && ((r_lane == 2'd3) || last);

    // Advance lane and shift register; restart after every emitted word
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_lane  <= 2'd0;
            r_shift <= 24'h0;
        end else if (xfer) begin
            if (word_we) begin
                r_lane  <= 2'd0;
                r_shift <= 24'h0;
            end else begin
                r_lane  <= r_lane + 2'd1;
                r_shift <= {r_shift[15:0], ld_byte};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_rom_loader
//  Description : Instruction store with a byte-stream program loader and a
//                combinational fetch port. Holds the core in reset until the
//                final program word has been written.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = INST_MEM_NUM_LOG2
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_i,
    input  logic [31:0]          addr_i,
    output logic [31:0]          inst_o,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [LD_BYTE_W-1:0] ld_byte_i,
    input  logic                 ld_last_i,
    output logic                 cpu_rst_o,
    output logic                 load_done_o,
    output logic                 ovf_o,
    output logic [ADDR_W:0]      word_cnt_o
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] C_FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;
    logic              r_last_seen;
    logic [ADDR_W:0]   r_word_cnt;
    logic              r_ovf;
    logic [31:0]       r_mem [DEPTH];

    logic              w_ready;
    logic              w_cpu_rst;
    logic              w_done;
    logic              w_xfer;
    logic              w_full;
    logic [31:0]       w_word;
    logic              w_word_we;
    logic              w_store_we;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_hit;
    logic              w_unused;

    assign w_xfer     = ld_valid_i && w_ready;
    assign w_full     = (r_word_cnt == C_FULL_CNT);
    assign w_store_we = w_word_we && !w_full && (rst != RST_ENABLE);

    ld_word_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .ld_byte (ld_byte_i),
        .xfer    (w_xfer),
        .last    (ld_last_i),
        .word    (w_word),
        .word_we (w_word_we)
    );

    // State register; reset re-holds the core and restarts loading at index 0
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= LD_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake/core-control outputs. The cycle between the
    // final write and entering RUN refuses bytes so nothing lands after "last".
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_cpu_rst   = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            LD_LOAD: begin
                w_ready = !r_last_seen;
                if (r_last_seen) begin
                    w_state_nxt = LD_RUN;
                end
            end
            LD_RUN: begin
                w_cpu_rst = 1'b0;
                w_done    = 1'b1;
            end
            default: begin
                w_state_nxt = LD_LOAD;
            end
        endcase
    end

    // Load bookkeeping: end-of-program flag, word counter, sticky overflow
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_last_seen <= 1'b0;
            r_word_cnt  <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_xfer && ld_last_i) begin
                r_last_seen <= 1'b1;
            end
            if (w_xfer && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_word_we && !w_full) begin
                r_word_cnt <= r_word_cnt + C_CNT_ONE;
            end
        end
    end

    // Program store; contents survive reset, only the valid window is cleared
    always_ff @(posedge clk) begin
        if (w_store_we) begin
            r_mem[r_word_cnt[ADDR_W-1:0]] <= w_word;
        end
    end

    // Fetch port: only words already written and inside the window are visible
    assign w_rd_idx = addr_i[ADDR_W+1:2];
    assign w_rd_hit = (ce_i == CHIP_ENABLE)
                   && (addr_i[31:ADDR_W+2] == '0)
                   && ({1'b0, w_rd_idx} < r_word_cnt);
    assign inst_o   = w_rd_hit ? r_mem[w_rd_idx] : ZERO_WORD;

    // Byte offset within a word has no meaning for word fetches
    assign w_unused = ^addr_i[1:0];

    assign ld_ready_o  = w_ready;
    assign cpu_rst_o   = w_cpu_rst;
    assign load_done_o = w_done;
    assign ovf_o       = r_ovf;
    assign word_cnt_o  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_rom_loader
//  Description : Scoreboard bench for inst_rom_loader. Stimulus queues the
//                expected value of an observable; a negedge monitor pops and
//                compares against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_rom_loader;

    localparam int OBS_INST   = 0;
    localparam int OBS_CNT    = 1;
    localparam int OBS_CPURST = 2;
    localparam int OBS_DONE   = 3;
    localparam int OBS_OVF    = 4;
    localparam int OBS_READY  = 5;
    localparam int OBS_S_INST = 6;
    localparam int OBS_S_CNT  = 7;
    localparam int OBS_S_OVF  = 8;
    localparam int OBS_S_RST  = 9;
    localparam int OBS_S_DONE = 10;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        ld_valid;
    logic        ld_valid_s;
    logic [7:0]  ld_byte;
    logic        ld_last;

    logic [31:0] inst,  inst_s;
    logic        ready, ready_s;
    logic        cpu_rst, cpu_rst_s;
    logic        done, done_s;
    logic        ovf, ovf_s;
    logic [10:0] word_cnt;
    logic [2:0]  word_cnt_s;

    chk_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    inst_rom_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
        .ld_valid_i(ld_valid), .ld_ready_o(ready), .ld_byte_i(ld_byte),
        .ld_last_i(ld_last), .cpu_rst_o(cpu_rst), .load_done_o(done),
        .ovf_o(ovf), .word_cnt_o(word_cnt)
    );

    inst_rom_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_s),
        .ld_valid_i(ld_valid_s), .ld_ready_o(ready_s), .ld_byte_i(ld_byte),
        .ld_last_i(ld_last), .cpu_rst_o(cpu_rst_s), .load_done_o(done_s),
        .ovf_o(ovf_s), .word_cnt_o(word_cnt_s)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            OBS_INST:   return inst;
            OBS_CNT:    return 32'(word_cnt);
            OBS_CPURST: return 32'(cpu_rst);
            OBS_DONE:   return 32'(done);
            OBS_OVF:    return 32'(ovf);
            OBS_READY:  return 32'(ready);
            OBS_S_INST: return inst_s;
            OBS_S_CNT:  return 32'(word_cnt_s);
            OBS_S_OVF:  return 32'(ovf_s);
            OBS_S_RST:  return 32'(cpu_rst_s);
            OBS_S_DONE: return 32'(done_s);
            default:    return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = sb.pop_front();
            act = observe(c.sel);
            n_total++;
            if (act === c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_obs(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic send_byte(input bit s, input logic [7:0] b, input bit last);
        ld_byte = b;
        ld_last = last;
        if (s) ld_valid_s = 1'b1;
        else   ld_valid   = 1'b1;
        tick();
        ld_valid   = 1'b0;
        ld_valid_s = 1'b0;
        ld_last    = 1'b0;
    endtask

    task automatic fetch(input int sel, input logic [31:0] a, input logic [31:0] exp, input string name);
        ce   = 1'b1;
        addr = a;
        expect_obs(sel, exp, name);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Stream bytes into the large instance, optionally with random idle gaps
    task automatic stream(input logic [7:0] bytes[$], input bit gaps);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) tick();
            end
            send_byte(1'b0, bytes[i], i == bytes.size() - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog[$];
        rst = 1'b1; ce = 1'b0; addr = 32'h0;
        ld_valid = 1'b0; ld_valid_s = 1'b0; ld_byte = 8'h00; ld_last = 1'b0;
        tick();
        do_reset();

        // Reset state
        expect_obs(OBS_CNT,    32'd0, "rst_cnt");
        expect_obs(OBS_CPURST, 32'd1, "rst_cpu_rst");
        expect_obs(OBS_DONE,   32'd0, "rst_done");
        expect_obs(OBS_OVF,    32'd0, "rst_ovf");
        expect_obs(OBS_READY,  32'd1, "rst_ready");
        fetch(OBS_INST, 32'h0, 32'h0, "rst_fetch0");

        // Two-word program
        prog = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h00, 8'h05};
        stream(prog, 1'b0);
        expect_obs(OBS_CNT,    32'd2, "p1_cnt");
        expect_obs(OBS_CPURST, 32'd1, "p1_cpu_rst_held");
        tick();
        expect_obs(OBS_CPURST, 32'd0, "p1_cpu_rst_fall");
        expect_obs(OBS_DONE,   32'd1, "p1_done");
        expect_obs(OBS_READY,  32'd0, "p1_ready_run");
        fetch(OBS_INST, 32'h0,    32'h3C01_1234, "p1_fetch0");
        fetch(OBS_INST, 32'h4,    32'h3421_0005, "p1_fetch4");
        fetch(OBS_INST, 32'h8,    32'h0000_0000, "p1_fetch8");
        fetch(OBS_INST, 32'h7,    32'h3421_0005, "p1_fetch7_lsb_ignored");
        fetch(OBS_INST, 32'h1000, 32'h0000_0000, "p1_fetch_out_window");

        // RUN: loader traffic ignored, ce gates the output
        ld_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ld_byte = 8'($urandom);
            ce      = i[0];
            addr    = 32'h0;
            expect_obs(OBS_READY, 32'd0, "run_ready");
            expect_obs(OBS_INST, i[0] ? 32'h3C01_1234 : 32'h0, "run_inst_ce");
            tick();
        end
        ld_valid = 1'b0;
        expect_obs(OBS_CNT, 32'd2, "run_cnt_unchanged");
        fetch(OBS_INST, 32'h4, 32'h3421_0005, "run_store_unchanged");

        // Partial final word is zero-padded
        do_reset();
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        stream(prog, 1'b0);
        expect_obs(OBS_CNT, 32'd2, "p2_cnt");
        tick();
        fetch(OBS_INST, 32'h0, 32'hAABB_CCDD, "p2_fetch0");
        fetch(OBS_INST, 32'h4, 32'hEE00_0000, "p2_fetch4");

        // Reset in the middle of a load
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(1'b0, 8'h50 + 8'(i), 1'b0);
        do_reset();
        expect_obs(OBS_CPURST, 32'd1, "mid_cpu_rst");
        expect_obs(OBS_CNT,    32'd0, "mid_cnt");
        fetch(OBS_INST, 32'h0, 32'h0, "mid_fetch0_hidden");
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        stream(prog, 1'b0);
        tick();
        expect_obs(OBS_CNT, 32'd1, "mid_new_cnt");
        fetch(OBS_INST, 32'h0, 32'h1122_3344, "mid_new_fetch0");

        // Back-to-back vs gapped streams produce the same result
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
            stream(prog, pass == 1);
            tick();
            expect_obs(OBS_CNT,  32'd3, "gap_cnt");
            expect_obs(OBS_DONE, 32'd1, "gap_done");
            fetch(OBS_INST, 32'h0, 32'hDEAD_BEEF, "gap_fetch0");
            fetch(OBS_INST, 32'h4, 32'h0123_4567, "gap_fetch4");
            fetch(OBS_INST, 32'h8, 32'h89AB_0000, "gap_fetch8");
        end

        // Small store: overflow, still reaches RUN
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            send_byte(1'b1, 8'(i), i == 20);
            if (i == 16) begin
                expect_obs(OBS_S_CNT, 32'd4, "small_cnt_full");
                expect_obs(OBS_S_OVF, 32'd0, "small_ovf_before");
            end
            if (i == 17) expect_obs(OBS_S_OVF, 32'd1, "small_ovf_first_drop");
        end
        tick();
        expect_obs(OBS_S_CNT,  32'd4, "small_cnt_final");
        expect_obs(OBS_S_OVF,  32'd1, "small_ovf_sticky");
        expect_obs(OBS_S_RST,  32'd0, "small_cpu_rst");
        expect_obs(OBS_S_DONE, 32'd1, "small_done");
        fetch(OBS_S_INST, 32'h10, 32'h0,          "small_fetch10");
        fetch(OBS_S_INST, 32'h0,  32'h0102_0304, "small_fetch0");
        fetch(OBS_S_INST, 32'hC,  32'h0D0E_0F10, "small_fetchC");

        tick();
        tick();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
